// File: rtl/jtag_pkg.sv
// Shared types and constants for the USER4 data-register channel.
//   scan_state_t : DR scan sequencer state
//   BYTE_BITS    : length of an upload scan
//   bit_cnt_w()  : counter width able to hold 0 .. result_width+1
package jtag_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int BYTE_BITS = 8;

    // The bit counter saturates one past the readback length, so it must
    // represent result_width+1 without wrapping.
    function automatic int bit_cnt_w(input int result_width);
        return $clog2(result_width + 2);
    endfunction

endpackage

// File: rtl/jtag_byte_fifo.sv
// Synchronous FIFO for bytes uploaded through the DR channel.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   push, push_data : write request and data (dropped when full unless popping)
//   pop           : read request (ignored when empty)
//   pop_data      : head entry
//   full, empty   : occupancy flags
module jtag_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/jtag_dr_channel.sv
// USER4 DR channel: sequences capture/shift/update scans from the BSCAN
// primitive into a byte upload stream and a result readback path.
// Everything runs on tck.
// Ports:
//   tck, test_logic_reset       : JTAG clock, asynchronous active-high reset
//   ir_is_user                  : IR holds USER4; gates every DR strobe
//   capture_dr/shift_dr/update_dr, tdi, tdo : TAP strobes and serial data
//   byte_valid/byte_data/byte_ready : inbound byte stream (FIFO head)
//   result_data/result_valid    : solver result captured for readback
//   overflow, scan_error        : sticky error flags
//   byte_count                  : bytes accepted into the FIFO, wrapping
//
// state | meaning
// IDLE  | no scan open; update_dr is ignored
// SCAN  | captured, shifting; update_dr closes the scan and classifies it
module jtag_dr_channel
    import jtag_pkg::*;
#(
    parameter int                      RESULT_WIDTH = 64,
    parameter int                      FIFO_DEPTH   = 4,
    parameter logic [RESULT_WIDTH-1:0] PENDING_WORD = '1
) (
    input  logic                    tck,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic                    tdi,
    output logic                    tdo,
    output logic                    byte_valid,
    output logic [7:0]              byte_data,
    input  logic                    byte_ready,
    input  logic [RESULT_WIDTH-1:0] result_data,
    input  logic                    result_valid,
    output logic                    overflow,
    output logic                    scan_error,
    output logic [31:0]             byte_count
);

    localparam int               CNT_W    = bit_cnt_w(RESULT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(RESULT_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(BYTE_BITS);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(RESULT_WIDTH);

    scan_state_t             state;
    logic [RESULT_WIDTH-1:0] shift_q;
    logic [7:0]              rx_q;
    logic [CNT_W-1:0]        bit_cnt;

    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic push_accepted;
    logic scan_close;

    // capture_dr has priority, so a simultaneous capture restarts rather than closes.
    assign scan_close = (state == SCAN) && ir_is_user && update_dr && !capture_dr;

    // Push is combinational so the byte lands in the FIFO on the update edge itself.
    assign fifo_push     = scan_close && (bit_cnt == CNT_BYTE);
    assign fifo_pop      = byte_valid && byte_ready;
    assign push_accepted = fifo_push && (!fifo_full || fifo_pop);

    assign byte_valid = !fifo_empty;
    assign tdo        = shift_q[0];

    jtag_byte_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (tck),
        .rst       (test_logic_reset),
        .push      (fifo_push),
        .push_data (rx_q),
        .pop       (fifo_pop),
        .pop_data  (byte_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state      <= IDLE;
            shift_q    <= '0;
            rx_q       <= '0;
            bit_cnt    <= '0;
            overflow   <= 1'b0;
            scan_error <= 1'b0;
            byte_count <= '0;
        end else begin
            if (push_accepted)              byte_count <= byte_count + 32'd1;
            if (fifo_push && !push_accepted) overflow  <= 1'b1;

            if (ir_is_user) begin
                case (state)
                    IDLE: begin
                        if (capture_dr) begin
                            shift_q <= result_valid ? result_data : PENDING_WORD;
                            bit_cnt <= '0;
                            state   <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (capture_dr) begin
                            shift_q <= result_valid ? result_data : PENDING_WORD;
                            bit_cnt <= '0;
                        end else if (update_dr) begin
                            state <= IDLE;
                            if ((bit_cnt != CNT_BYTE) && (bit_cnt != CNT_WORD))
                                scan_error <= 1'b1;
                        end else if (shift_dr) begin
                            shift_q <= {tdi, shift_q[RESULT_WIDTH-1:1]};
                            rx_q    <= {tdi, rx_q[7:1]};
                            // Saturation keeps long scans from wrapping back onto a valid length.
                            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
